// File: rtl/result_unload_pkg.sv
// rtl/result_unload_pkg.sv - shared constants and state type for the load/unload datapath
package result_unload_pkg;

    localparam int UNLOAD_WORD_W    = 32;
    localparam int UNLOAD_NUM_WORDS = 8;
    localparam int UNLOAD_FRAME_W   = UNLOAD_WORD_W * UNLOAD_NUM_WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

endpackage

// File: rtl/result_unload_piso_buffer.sv
// rtl/result_unload_piso_buffer.sv - parallel-in/serial-out frame register with word index
module piso_buffer
    import result_unload_pkg::*;
#(
    parameter int WORD_W    = UNLOAD_WORD_W,
    parameter int NUM_WORDS = UNLOAD_NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_en,
    input  logic [WORD_W*NUM_WORDS-1:0] frame_i,
    input  logic                        advance,
    output logic [WORD_W-1:0]           word_o,
    output logic                        last_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [WORD_W*NUM_WORDS-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]            idx_q, idx_d;

    // A load on the final transfer wins over the advance so the new frame starts at word 0.
    always_comb begin
        frame_d = frame_q;
        idx_d   = idx_q;
        if (load_en) begin
            frame_d = frame_i;
            idx_d   = '0;
        end else if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            idx_q   <= '0;
        end else begin
            frame_q <= frame_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o = frame_q[idx_q*WORD_W +: WORD_W];
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/result_unload.sv
// rtl/result_unload.sv - captures a wide result frame and streams it out word by word
module result_unload
    import result_unload_pkg::*;
#(
    parameter int WORD_W      = UNLOAD_WORD_W,
    parameter int NUM_WORDS   = UNLOAD_NUM_WORDS,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_W*NUM_WORDS-1:0] result_i,
    input  logic                        result_valid_i,
    output logic                        result_ready_o,
    output logic [WORD_W-1:0]           data_o,
    output logic                        data_valid_o,
    input  logic                        data_ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic [FRAME_CNT_W-1:0]      frame_cnt_o
);

    unload_state_t          state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic buf_last;
    logic load_en;
    logic xfer;
    logic last_xfer;
    logic sending;

    assign sending   = (state_q == SEND);
    assign xfer      = sending && data_ready_i;
    assign last_xfer = xfer && buf_last;

    // Ready is combinational from data_ready_i so a new frame can follow with no bubble.
    assign result_ready_o = !sending || last_xfer;
    assign load_en        = result_valid_i && result_ready_o;

    piso_buffer #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_piso_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (load_en),
        .frame_i (result_i),
        .advance (xfer),
        .word_o  (data_o),
        .last_o  (buf_last)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (result_valid_i) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    if (!result_valid_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign data_valid_o = sending;
    assign last_o       = sending && buf_last;
    assign busy_o       = sending;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
